// File: rtl/apu_inflight_tracker_pkg.sv
// Shared APU core definitions: flag width, default in-flight depth and the
// writeback FSM state encoding used by the in-flight tracker.
package apu_inflight_tracker_pkg;

  localparam int unsigned APU_FLAGS_W       = 5;
  localparam int unsigned APU_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,  // output stage free
    WB_OUT   = 2'd1,  // output stage holds a result
    WB_SKID  = 2'd2   // output stage and skid register both hold results
  } wb_state_e;

endpackage

// File: rtl/apu_inflight_tracker_tag.sv
// In-order tag FIFO holding destination addresses of issued APU operations.
// Besides push/pop it exposes a flat valid/address view of every slot so the
// parent can run hazard compares against all outstanding destinations.
module apu_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 6,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [W-1:0]       data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o,
  output logic [W-1:0]       head_o,
  output logic [DEPTH-1:0]   valid_o,
  output logic [DEPTH*W-1:0] addr_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = vld_q;

  // Full/empty come from the registered count, so a same-cycle pop never
  // frees room for a push into a full FIFO.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state for pointers, occupancy and per-slot valid bits; pointers
  // wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (push_ok) begin
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      vld_d[wr_ptr_q] = 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      vld_d[rd_ptr_q] = 1'b0;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Address storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Flatten the storage for the hazard compare in the parent.
  always_comb begin
    addr_o = '0;
    for (int i = 0; i < DEPTH; i++) addr_o[i*W +: W] = mem_q[i];
  end

endmodule

// File: rtl/apu_inflight_tracker.sv
// Tracks APU operations between issue and register-file writeback: gates
// issue on tag-FIFO space, pairs returning results with their destination
// address in order, buffers writeback through an output stage plus skid
// register, and flags read-after-write hazards on pending destinations.
module apu_inflight_tracker
  import apu_inflight_tracker_pkg::*;
#(
  parameter  int DEPTH   = APU_DEPTH_DEFAULT,
  parameter  int WADDR_W = 6,
  parameter  int DATA_W  = 32,
  parameter  int FLAGS_W = APU_FLAGS_W,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid_i,
  input  logic [WADDR_W-1:0]   issue_waddr_i,
  output logic                 issue_ready_o,
  output logic                 apu_req_o,
  input  logic                 apu_gnt_i,
  input  logic                 apu_rvalid_i,
  input  logic [DATA_W-1:0]    apu_result_i,
  input  logic [FLAGS_W-1:0]   apu_flags_i,
  output logic                 wb_valid_o,
  output logic [WADDR_W-1:0]   wb_waddr_o,
  output logic [DATA_W-1:0]    wb_wdata_o,
  output logic [FLAGS_W-1:0]   wb_flags_o,
  input  logic                 wb_ready_i,
  input  logic [3*WADDR_W-1:0] dep_raddr_i,
  output logic [2:0]           dep_hazard_o,
  output logic [CNT_W-1:0]     inflight_cnt_o,
  output logic                 err_spurious_o,
  output logic                 err_overflow_o
);

  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_cnt;
  logic [WADDR_W-1:0]       head_waddr;
  logic [DEPTH-1:0]         fifo_vld;
  logic [DEPTH*WADDR_W-1:0] fifo_addr;
  logic                     rv_pop, spurious;

  wb_state_e          state_q, state_d;
  logic               load_out, out_from_skid, load_skid, overflow;
  logic [WADDR_W-1:0] out_waddr_q, skid_waddr_q;
  logic [DATA_W-1:0]  out_data_q, skid_data_q;
  logic [FLAGS_W-1:0] out_flags_q, skid_flags_q;
  logic               err_spurious_q, err_overflow_q;
  logic [CNT_W-1:0]   wb_cnt;
  logic [WADDR_W-1:0] raddr;
  logic               hit;

  assign apu_req_o     = issue_valid_i & ~fifo_full;
  assign issue_ready_o = apu_req_o & apu_gnt_i;
  assign rv_pop        = apu_rvalid_i & ~fifo_empty;
  assign spurious      = apu_rvalid_i & fifo_empty;

  apu_tag_fifo #(.DEPTH(DEPTH), .W(WADDR_W)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue_ready_o),
    .data_i  (issue_waddr_i),
    .pop_i   (rv_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt),
    .head_o  (head_waddr),
    .valid_o (fifo_vld),
    .addr_o  (fifo_addr)
  );

  // Writeback FSM next-state and datapath steering. A result arriving while
  // both stages are occupied and the port stalls is dropped (its tag is
  // still consumed).
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    overflow      = 1'b0;
    case (state_q)
      WB_EMPTY: begin
        if (rv_pop) begin
          state_d  = WB_OUT;
          load_out = 1'b1;
        end
      end
      WB_OUT: begin
        if (wb_ready_i) begin
          if (rv_pop) load_out = 1'b1;
          else        state_d  = WB_EMPTY;
        end else if (rv_pop) begin
          state_d   = WB_SKID;
          load_skid = 1'b1;
        end
      end
      WB_SKID: begin
        if (wb_ready_i) begin
          out_from_skid = 1'b1;
          if (rv_pop) load_skid = 1'b1;
          else        state_d   = WB_OUT;
        end else if (rv_pop) begin
          overflow = 1'b1;
        end
      end
      default: state_d = WB_EMPTY;
    endcase
  end

  // FSM state and error pulses; registered so they read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= WB_EMPTY;
      err_spurious_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_spurious_q <= spurious;
      err_overflow_q <= overflow;
    end
  end

  // Output stage and skid payload; qualified by the FSM state, no reset.
  always_ff @(posedge clk) begin
    if (load_out) begin
      out_waddr_q <= head_waddr;
      out_data_q  <= apu_result_i;
      out_flags_q <= apu_flags_i;
    end else if (out_from_skid) begin
      out_waddr_q <= skid_waddr_q;
      out_data_q  <= skid_data_q;
      out_flags_q <= skid_flags_q;
    end
    if (load_skid) begin
      skid_waddr_q <= head_waddr;
      skid_data_q  <= apu_result_i;
      skid_flags_q <= apu_flags_i;
    end
  end

  assign wb_valid_o     = (state_q != WB_EMPTY);
  assign wb_waddr_o     = out_waddr_q;
  assign wb_wdata_o     = out_data_q;
  assign wb_flags_o     = out_flags_q;
  assign err_spurious_o = err_spurious_q;
  assign err_overflow_o = err_overflow_q;

  // Number of results buffered on the writeback side.
  always_comb begin
    case (state_q)
      WB_OUT:  wb_cnt = CNT_W'(1);
      WB_SKID: wb_cnt = CNT_W'(2);
      default: wb_cnt = '0;
    endcase
  end

  assign inflight_cnt_o = fifo_cnt + wb_cnt;

  // RAW hazard: operand matches any pending destination; x0 never hazards.
  always_comb begin
    dep_hazard_o = '0;
    raddr        = '0;
    hit          = 1'b0;
    for (int i = 0; i < 3; i++) begin
      raddr = dep_raddr_i[i*WADDR_W +: WADDR_W];
      hit   = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (fifo_vld[j] && (fifo_addr[j*WADDR_W +: WADDR_W] == raddr)) hit = 1'b1;
      end
      if ((state_q != WB_EMPTY) && (out_waddr_q == raddr))  hit = 1'b1;
      if ((state_q == WB_SKID) && (skid_waddr_q == raddr))  hit = 1'b1;
      dep_hazard_o[i] = hit && (raddr != '0);
    end
  end

endmodule
